// File: rtl/mul_div_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle; results appear WIDTH+2 cycles after Start, or 1 cycle later for the divide-by-zero and overflow cases.
// Stall holds upstream while the unit is busy or a Start is being accepted.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
    logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;

    function automatic logic a_is_signed(input logic [2:0] f);
        return !(f[0] && (f[1] || f[2]));
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return a_is_signed(f) && (f != 3'b010);
    endfunction

    // Incoming operand decode, used only on the accept edge
    logic             in_neg_a, in_neg_b, in_div0, in_ovf, accept;
    logic [WIDTH-1:0] in_mag_a, in_mag_b, fast_result;

    assign in_neg_a = a_is_signed(Funct3) && SrcA[WIDTH-1];
    assign in_neg_b = b_is_signed(Funct3) && SrcB[WIDTH-1];
    assign in_mag_a = in_neg_a ? -SrcA : SrcA;
    assign in_mag_b = in_neg_b ? -SrcB : SrcB;
    assign in_div0  = Funct3[2] && (SrcB == '0);
    assign in_ovf   = Funct3[2] && !Funct3[0] && (SrcB == '1)
                      && (SrcA == {1'b1, {(WIDTH-1){1'b0}}});
    assign accept   = Start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        fast_result = '0;
        if (in_div0)
            fast_result = Funct3[1] ? SrcA : '1;
        else
            fast_result = Funct3[1] ? '0 : SrcA;
    end

    // Latched operand decode drives the datapath during CALC and FIX
    logic                   neg_a, neg_b;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [WIDTH:0]         mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]     product, product_s;
    logic [WIDTH-1:0]       quot_s, rem_s;

    assign neg_a     = a_is_signed(funct3_q) && src_a_q[WIDTH-1];
    assign neg_b     = b_is_signed(funct3_q) && src_b_q[WIDTH-1];
    assign mag_a     = neg_a ? -src_a_q : src_a_q;
    assign mag_b     = neg_b ? -src_b_q : src_b_q;

    // Multiply: acc holds the running high half, lo shifts the multiplier out and product bits in.
    // Divide: acc is the partial remainder, lo shifts dividend bits out and quotient bits in.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    assign product   = {acc_q, lo_q};
    assign product_s = (neg_a ^ neg_b) ? -product : product;
    assign quot_s    = (neg_a ^ neg_b) ? -lo_q : lo_q;
    assign rem_s     = neg_a ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    funct3_d = Funct3;
                    src_a_d  = SrcA;
                    src_b_d  = SrcB;
                    cnt_d    = '0;
                    acc_d    = '0;
                    lo_d     = Funct3[2] ? in_mag_a : in_mag_b;
                    if (in_div0 || in_ovf) begin
                        state_d  = DONE;
                        result_d = fast_result;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (funct3_q[2]) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                case (funct3_q)
                    3'b000:                 result_d = product_s[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: result_d = product_s[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101:         result_d = quot_s;
                    default:                result_d = rem_s;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign Busy   = (state_q == CALC) || (state_q == FIX);
    assign Done   = (state_q == DONE);
    assign Stall  = Busy || accept;
    assign Result = result_q;
endmodule
